// File: rtl/branch_pkg.sv
// Shared encodings for the LegV8 branch control unit: opcodes, PC select,
// bus enable, function select, sequencer states and condition codes.
package branch_pkg;
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [5:0]  OP_BL    = 6'b100101;
  localparam logic [10:0] OP_BR    = 11'b11010110000;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_REG  = 2'b10;
  localparam logic [1:0] PS_REL  = 2'b11;

  localparam logic [1:0] EN_ALU  = 2'b00;
  localparam logic [1:0] EN_RAM  = 2'b01;
  localparam logic [1:0] EN_PC4  = 2'b10;
  localparam logic [1:0] EN_NONE = 2'b11;

  localparam logic [4:0] FS_PASS_A = 5'b00000;
  localparam logic [4:0] FS_PASS_B = 5'b00100;

  typedef enum logic {S_DECODE = 1'b0, S_CB2 = 1'b1} state_t;

  localparam logic [3:0] C_EQ = 4'h0, C_NE = 4'h1, C_HS = 4'h2, C_LO = 4'h3;
  localparam logic [3:0] C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7;
  localparam logic [3:0] C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB;
  localparam logic [3:0] C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE, C_NV = 4'hF;
endpackage

// File: rtl/branch_control_unit_cond_eval.sv
// B.cond evaluator: condition code against {V,C,N,Z} status.
module cond_eval
  import branch_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] status,
  output logic       taken
);
  logic v, c, n, z;
  assign {v, c, n, z} = status;

  always_comb begin
    taken = 1'b1;
    case (cond)
      C_EQ: taken = z;
      C_NE: taken = !z;
      C_HS: taken = c;
      C_LO: taken = !c;
      C_MI: taken = n;
      C_PL: taken = !n;
      C_VS: taken = v;
      C_VC: taken = !v;
      C_HI: taken = c && !z;
      C_LS: taken = !(c && !z);
      C_GE: taken = (n == v);
      C_LT: taken = (n != v);
      C_GT: taken = !z && (n == v);
      C_LE: taken = !(!z && (n == v));
      default: taken = 1'b1;
    endcase
  end
endmodule

// File: rtl/branch_control_unit.sv
// Branch decoder/sequencer: one instruction per handshake, registered control
// word one cycle later; CBZ/CBNZ optionally take a second cycle for alu_zero.
module branch_control_unit
  import branch_pkg::*;
#(
  parameter int         DATA_WIDTH    = 64,
  parameter int         CW_WIDTH      = DATA_WIDTH + 30,
  parameter logic [4:0] LINK_REG      = 5'd30,
  parameter logic [4:0] ZERO_REG      = 5'd31,
  parameter bit         REG_ZERO_FLAG = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  instr_valid,
  input  logic [31:0]           instruction,
  input  logic [3:0]            status,
  input  logic                  alu_zero,
  output logic                  instr_ready,
  output logic                  cw_valid,
  output logic [CW_WIDTH-1:0]   CW,
  output logic [4:0]            DA,
  output logic [4:0]            SA,
  output logic [4:0]            SB,
  output logic [4:0]            FS,
  output logic [1:0]            PS,
  output logic [1:0]            enable,
  output logic                  regWrite,
  output logic                  memWrite,
  output logic                  PC_sel,
  output logic                  B_sel,
  output logic                  status_load,
  output logic [DATA_WIDTH-1:0] k,
  output logic                  state,
  output logic                  branch_taken,
  output logic                  illegal
);
  state_t fsm_q, n_fsm;
  logic   cbnz_q, n_cbnz;
  logic   cond_taken;

  logic [4:0]            n_da, n_sa, n_sb, n_fs;
  logic [1:0]            n_ps, n_en;
  logic                  n_rw, n_pcsel, n_bsel, n_state, n_valid, n_illegal;
  logic [DATA_WIDTH-1:0] n_k, k26, k19;

  assign k26 = {{(DATA_WIDTH-26){instruction[25]}}, instruction[25:0]};
  assign k19 = {{(DATA_WIDTH-19){instruction[23]}}, instruction[23:5]};

  cond_eval u_cond (.cond(instruction[3:0]), .status(status), .taken(cond_taken));

  assign instr_ready = (fsm_q == S_DECODE);
  assign CW = {DA, SA, SB, FS, PS, enable, regWrite, memWrite, PC_sel, B_sel,
               status_load, k, state};

  always_comb begin
    n_da = ZERO_REG; n_sa = ZERO_REG; n_sb = ZERO_REG; n_fs = 5'd0;
    n_ps = PS_HOLD;  n_en = EN_ALU;   n_rw = 1'b0;     n_pcsel = 1'b0;
    n_bsel = 1'b0;   n_k = '0;        n_state = 1'b0;  n_valid = 1'b0;
    n_illegal = 1'b0; n_fsm = fsm_q;  n_cbnz = cbnz_q;
    if (fsm_q == S_CB2) begin
      // Second CB cycle: operands stay on the bus, alu_zero now resolves PS.
      n_da = DA; n_sa = SA; n_sb = SB; n_fs = FS; n_en = enable;
      n_rw = regWrite; n_pcsel = PC_sel; n_bsel = B_sel; n_k = k;
      n_ps = (alu_zero ^ cbnz_q) ? PS_REL : PS_INC;
      n_state = 1'b1; n_valid = 1'b1; n_fsm = S_DECODE;
    end else if (instr_valid) begin
      n_valid = 1'b1;
      if (instruction[31:26] == OP_B || instruction[31:26] == OP_BL) begin
        n_k = k26; n_ps = PS_REL; n_en = EN_NONE; n_pcsel = 1'b1;
        if (instruction[31]) begin
          n_rw = 1'b1; n_da = LINK_REG; n_en = EN_PC4;
        end
      end else if (instruction[31:21] == OP_BR) begin
        n_sa = instruction[9:5]; n_fs = FS_PASS_A; n_en = EN_ALU;
        n_ps = PS_REG; n_pcsel = 1'b1;
      end else if (instruction[31:24] == OP_BCOND) begin
        n_k = k19; n_en = EN_NONE; n_ps = cond_taken ? PS_REL : PS_INC;
      end else if (instruction[31:24] == OP_CBZ || instruction[31:24] == OP_CBNZ) begin
        n_k = k19; n_sb = instruction[4:0]; n_fs = FS_PASS_B; n_en = EN_NONE;
        n_cbnz = instruction[24];
        if (REG_ZERO_FLAG) begin
          n_ps = PS_HOLD; n_fsm = S_CB2;
        end else begin
          n_ps = (alu_zero ^ instruction[24]) ? PS_REL : PS_INC;
        end
      end else begin
        n_ps = PS_INC; n_illegal = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      DA <= ZERO_REG; SA <= ZERO_REG; SB <= ZERO_REG; FS <= 5'd0;
      PS <= PS_HOLD; enable <= EN_ALU; regWrite <= 1'b0; memWrite <= 1'b0;
      PC_sel <= 1'b0; B_sel <= 1'b0; status_load <= 1'b0; k <= '0;
      state <= 1'b0; cw_valid <= 1'b0; branch_taken <= 1'b0; illegal <= 1'b0;
      fsm_q <= S_DECODE; cbnz_q <= 1'b0;
    end else begin
      DA <= n_da; SA <= n_sa; SB <= n_sb; FS <= n_fs;
      PS <= n_ps; enable <= n_en; regWrite <= n_rw; memWrite <= 1'b0;
      PC_sel <= n_pcsel; B_sel <= n_bsel; status_load <= 1'b0; k <= n_k;
      state <= n_state; cw_valid <= n_valid; branch_taken <= n_ps[1];
      illegal <= n_illegal; fsm_q <= n_fsm; cbnz_q <= n_cbnz;
    end
  end
endmodule
